div_unit: RTL and testbench

Multi-cycle 32-bit integer divider in the EX stage, started by the EX logic for DIV/DIVU operations taken from the ID/EX register. It runs a 32-iteration restoring division and returns `{remainder, quotient}` with a ready flag. While it is busy, EX drives the stall request that freezes ID/EX and the earlier stages. It also obeys the pipeline flush.

---
 rtl/div_unit_pkg.sv | 25 ++
 rtl/div_if.sv | 23 ++
 rtl/div_unit.sv | 122 ++++++++++++
 tb/tb_div_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared widths, state encoding and operand helpers for the EX-stage divider.
package div_unit_pkg;

    localparam int REG_W  = 32;
    localparam int DREG_W = 64;
    localparam int WORK_W = 65;
    localparam int CNT_W  = 6;

    // Number of restoring steps needed to produce a full 32-bit quotient.
    localparam logic [CNT_W-1:0] ITER_COUNT = 6'd32;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    // Absolute value of an operand when it is interpreted as signed, raw value otherwise.
    function automatic logic [REG_W-1:0] magnitude(input logic [REG_W-1:0] value,
                                                   input logic             as_signed);
        return (as_signed && value[REG_W-1]) ? -value : value;
    endfunction

endpackage

// File: rtl/div_if.sv
// div_if: request/result bundle between the EX stage and the divider.
interface div_if;
    import div_unit_pkg::*;

    logic               signed_div_i;
    logic [REG_W-1:0]   opdata1_i;
    logic [REG_W-1:0]   opdata2_i;
    logic               start_i;
    logic               annul_i;
    logic [DREG_W-1:0]  result_o;
    logic               ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );

endinterface

// File: rtl/div_unit.sv
// div_unit: 32-iteration restoring divider returning {remainder, quotient} with a ready flag.
module div_unit
    import div_unit_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    div_if.slave   bus
);

    div_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WORK_W-1:0]   work_q, work_d;
    logic [REG_W-1:0]    divisor_q, divisor_d;
    logic                quot_neg_q, quot_neg_d;
    logic                rem_neg_q, rem_neg_d;
    logic [DREG_W-1:0]   result_q, result_d;
    logic                ready_q, ready_d;

    logic [REG_W:0]      diff;
    logic [REG_W-1:0]    quot_fixed;
    logic [REG_W-1:0]    rem_fixed;

    // Trial subtraction of the divisor from the current partial remainder; bit 32 is the borrow.
    assign diff = {1'b0, work_q[63:32]} - {1'b0, divisor_q};

    // Quotient collects in the low word, remainder ends up in the top 32 bits of the work register.
    assign quot_fixed = quot_neg_q ? -work_q[31:0]  : work_q[31:0];
    assign rem_fixed  = rem_neg_q  ? -work_q[64:33] : work_q[64:33];

    // Next-state, datapath and output logic for the divider sequence.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        divisor_d  = divisor_q;
        quot_neg_d = quot_neg_q;
        rem_neg_d  = rem_neg_q;
        result_d   = result_q;
        ready_d    = ready_q;

        unique case (state_q)
            DIV_FREE: begin
                ready_d  = 1'b0;
                result_d = '0;
                if (bus.start_i && !bus.annul_i) begin
                    if (bus.opdata2_i == '0) begin
                        state_d = DIV_BY_ZERO;
                    end else begin
                        state_d    = DIV_ON;
                        cnt_d      = '0;
                        // Dividend sits one bit up so the first step already sees its MSB shifted in.
                        work_d     = {32'b0, magnitude(bus.opdata1_i, bus.signed_div_i), 1'b0};
                        divisor_d  = magnitude(bus.opdata2_i, bus.signed_div_i);
                        quot_neg_d = bus.signed_div_i & (bus.opdata1_i[REG_W-1] ^ bus.opdata2_i[REG_W-1]);
                        rem_neg_d  = bus.signed_div_i & bus.opdata1_i[REG_W-1];
                    end
                end
            end

            DIV_BY_ZERO: begin
                state_d  = DIV_END;
                work_d   = '0;
                result_d = '0;
                ready_d  = 1'b1;
            end

            DIV_ON: begin
                if (bus.annul_i || !bus.start_i) begin
                    state_d  = DIV_FREE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end else if (cnt_q != ITER_COUNT) begin
                    if (diff[REG_W]) begin
                        work_d = {work_q[63:0], 1'b0};
                    end else begin
                        work_d = {diff[31:0], work_q[31:0], 1'b1};
                    end
                    cnt_d = cnt_q + 6'd1;
                end else begin
                    state_d  = DIV_END;
                    result_d = {rem_fixed, quot_fixed};
                    ready_d  = 1'b1;
                end
            end

            DIV_END: begin
                if (!bus.start_i) begin
                    state_d  = DIV_FREE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end
            end
        endcase
    end

    // All divider state and registered outputs, cleared asynchronously by the active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= DIV_FREE;
            cnt_q      <= '0;
            work_q     <= '0;
            divisor_q  <= '0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            divisor_q  <= divisor_d;
            quot_neg_q <= quot_neg_d;
            rem_neg_q  <= rem_neg_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized and directed checks of div_unit against an arithmetic reference model.
module tb_div_unit;

    logic clk;
    logic rst;
    int   vectorCount;
    int   miscompareCount;

    div_if bus ();

    div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running pipeline clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a wedged run so the bench always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference divider: plain integer division with the divider's rules for zero and overflow.
    function automatic logic [63:0] refDivide(input logic isSigned,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) return 64'd0;
        if (isSigned) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'd0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            miscompareCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Counts edges from the sampling edge until ready, then checks latency, result, hold and release.
    task automatic waitAndCheck(input string tag, input int wantEdges,
                                input logic [63:0] expected, input logic origSigned);
        int edges;
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
            if (edges == 1) begin
                bus.opdata1_i    = $urandom;
                bus.opdata2_i    = $urandom;
                bus.signed_div_i = ~origSigned;
            end
        end while (!bus.ready_o && edges < 40);
        checkOutput({tag, "_latency"}, 64'(edges), 64'(wantEdges));
        checkOutput({tag, "_result"}, bus.result_o, expected);
        @(posedge clk);
        #1;
        checkOutput({tag, "_hold"}, {bus.ready_o, bus.result_o[62:0]}, {1'b1, expected[62:0]});
        @(negedge clk);
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        checkOutput({tag, "_release"}, {63'd0, bus.ready_o} | bus.result_o, 64'd0);
    endtask

    // Drives one division request on a falling edge and follows it to completion.
    task automatic applyStimulus(input logic isSigned, input logic [31:0] a,
                                 input logic [31:0] b, input string tag);
        logic [63:0] expected;
        expected = refDivide(isSigned, a, b);
        @(negedge clk);
        bus.signed_div_i = isSigned;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.annul_i      = 1'b0;
        bus.start_i      = 1'b1;
        waitAndCheck(tag, (b == 32'd0) ? 2 : 34, expected, isSigned);
    endtask

    // Directed scenarios followed by a randomized sweep.
    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        int          edges;

        vectorCount      = 0;
        miscompareCount  = 0;
        rst              = 1'b1;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd100;
        bus.opdata2_i    = 32'd7;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;

        #3;
        rst         = 1'b0;
        bus.start_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_hold", {63'd0, bus.ready_o} | bus.result_o, 64'd0);
        @(negedge clk);
        bus.start_i = 1'b0;
        rst         = 1'b1;

        applyStimulus(1'b0, 32'd100, 32'd7, "divu_100_7");
        applyStimulus(1'b1, -32'sd7, 32'd2, "div_m7_2");
        applyStimulus(1'b1, 32'd7, -32'sd2, "div_7_m2");
        applyStimulus(1'b0, 32'h1234_5678, 32'd0, "div_by_zero");
        applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
        applyStimulus(1'b0, 32'd1000, 32'd3, "back_to_back");

        // Flush at iteration 10, then a new request keeps start high straight out of the abort.
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd100;
        bus.opdata2_i    = 32'd7;
        bus.start_i      = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("annul_outputs", {63'd0, bus.ready_o} | bus.result_o, 64'd0);
        @(negedge clk);
        bus.annul_i      = 1'b0;
        bus.opdata1_i    = 32'hFFFF_FFFF;
        bus.opdata2_i    = 32'h0000_0010;
        waitAndCheck("divu_after_annul", 34, refDivide(1'b0, 32'hFFFF_FFFF, 32'h10), 1'b0);

        // Asynchronous reset between edges at iteration 20.
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd100;
        bus.opdata2_i    = 32'd7;
        bus.start_i      = 1'b1;
        repeat (21) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("reset_mid_iter", {63'd0, bus.ready_o} | bus.result_o, 64'd0);
        @(negedge clk);
        rst         = 1'b1;
        bus.start_i = 1'b0;
        applyStimulus(1'b0, 32'd100, 32'd7, "after_reset");

        // Asynchronous reset while a result is being presented.
        @(negedge clk);
        bus.opdata1_i = 32'd1000;
        bus.opdata2_i = 32'd10;
        bus.start_i   = 1'b1;
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (!bus.ready_o && edges < 40);
        checkOutput("end_before_reset", bus.result_o, refDivide(1'b0, 32'd1000, 32'd10));
        #2;
        rst = 1'b0;
        #1;
        checkOutput("reset_in_end", {63'd0, bus.ready_o} | bus.result_o, 64'd0);
        @(negedge clk);
        rst         = 1'b1;
        bus.start_i = 1'b0;
        applyStimulus(1'b1, 32'hFFFF_FF9C, 32'd7, "after_end_reset");

        for (int i = 0; i < 16; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            if (i % 3 == 1) b = $urandom_range(1, 20);
            if (i % 3 == 2) b = -32'($urandom_range(1, 20));
            if (i % 5 == 4) b = 32'd0;
            if (i == 7) begin
                s = 1'b1;
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            applyStimulus(s, a, b, $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
        $finish;
    end

endmodule
